// File: rtl/keysw_mmio_dev.sv
// keysw_mmio_dev: memory-mapped pushbutton/switch input peripheral.
//
// Answers loads and stores in the BASE..BASE+6 I/O window. KEY[3:0] and SW[9:0]
// are synchronised and debounced. Each group has sticky ready/overrun flags,
// so software can poll for input changes instead of sampling raw levels.
//
// Register map (byte addresses, even only):
//   BASE+0 KDATA (RO)  {12'b0, kdeb[3:0]}
//   BASE+2 SDATA (RO)  {6'b0,  sdeb[9:0]}
//   BASE+4 KCTRL       bit0 RDY, bit1 OVR, bit4 IE
//   BASE+6 SCTRL       same layout as KCTRL
//
// Optional feature: define KEYSW_IRQ_EN to implement the IE bits and a
// registered IRQ output. Without it, IE reads 0, IE writes are ignored, and
// IRQ is tied low.

// Two-flop synchroniser followed by a stable-count debounce engine for one
// input group. chg pulses for exactly the cycle whose closing edge updates deb.
module keysw_debounce #(
  parameter int               W          = 4,
  parameter int               DEB_CYCLES = 500000,
  parameter int               CNTBITS    = 20,
  parameter logic [W-1:0]     RST_VAL    = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] deb,
  output logic         chg
);

  localparam logic [CNTBITS-1:0] CNT_MAX = CNTBITS'(DEB_CYCLES - 1);

  logic [W-1:0]       sync_q1;
  logic [W-1:0]       sync_q2;
  logic [W-1:0]       cand;
  logic [CNTBITS-1:0] cnt;

  // Two-stage synchroniser for the asynchronous raw inputs.
  // NOTE: state registers use non-blocking assignments, so every flop samples
  // the pre-edge value of the others and the stage ordering stays intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= RST_VAL;
      sync_q2 <= RST_VAL;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce engine: restart the count on any change, and commit after
  // DEB_CYCLES consecutive stable cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= RST_VAL;
      cnt  <= '0;
      deb  <= RST_VAL;
    end else if (sync_q2 != cand) begin
      cand <= sync_q2;
      cnt  <= '0;
    end else if (cnt == CNT_MAX) begin
      if (deb != cand) deb <= cand;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // chg is high in the cycle that deb takes the new value.
  assign chg = (sync_q2 == cand) && (cnt == CNT_MAX) && (deb != cand);

endmodule

// Sticky RDY/OVR flag pair for one input group.
module keysw_flags (
  input  logic clk,
  input  logic rst_n,
  input  logic chg,
  input  logic rd_data,
  input  logic wr_ctrl,
  input  logic din_rdy,
  input  logic din_ovr,
  output logic rdy,
  output logic ovr
);

  logic clr_rdy;

  // A clear is a data read, or a control write of 0 to RDY. A coincident chg
  // wins the clear, and it does not raise OVR because software is consuming
  // the previous value at the same moment.
  assign clr_rdy = rd_data | (wr_ctrl & ~din_rdy);

  // Flag update: set on chg, clear by data read or control write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy <= 1'b0;
      ovr <= 1'b0;
    end else begin
      if (chg)          rdy <= 1'b1;
      else if (rd_data) rdy <= 1'b0;
      else if (wr_ctrl) rdy <= rdy & din_rdy;

      if (chg && rdy && !clr_rdy) ovr <= 1'b1;
      else if (wr_ctrl)           ovr <= ovr & din_ovr;
    end
  end

endmodule

// Top level: bus decode, register file and the two input groups.
module keysw_mmio_dev #(
  parameter int                 DBITS      = 16,
  parameter int                 DEB_CYCLES = 500000,
  parameter int                 CNTBITS    = 20,
  parameter logic [DBITS-1:0]   BASE       = 16'hFFF0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  input  logic [DBITS-1:0] ADDR,
  input  logic             RE,
  input  logic             WE,
  input  logic [DBITS-1:0] DIN,
  output logic [DBITS-1:0] DOUT,
  output logic             HIT,
  output logic             IRQ
);

  typedef enum logic [1:0] {
    REG_KDATA = 2'd0,
    REG_SDATA = 2'd1,
    REG_KCTRL = 2'd2,
    REG_SCTRL = 2'd3
  } reg_sel_t;

  logic [DBITS-1:0] offset;
  reg_sel_t         reg_sel;
  logic [3:0]       kdeb;
  logic [9:0]       sdeb;
  logic             kchg;
  logic             schg;
  logic             krdy;
  logic             kovr;
  logic             srdy;
  logic             sovr;
  logic             kie;
  logic             sie;
  logic             rd_kdata;
  logic             rd_sdata;
  logic             wr_kctrl;
  logic             wr_sctrl;
  logic             unused_din;

  // Offset into the window. An address below BASE wraps to a large value,
  // so one unsigned compare covers both ends of the window.
  assign offset  = ADDR - BASE;
  assign HIT     = (offset < DBITS'(7)) && !ADDR[0];
  assign reg_sel = reg_sel_t'(offset[2:1]);

  // Bus strobes count only inside the window.
  assign rd_kdata = RE & HIT & (reg_sel == REG_KDATA);
  assign rd_sdata = RE & HIT & (reg_sel == REG_SDATA);
  assign wr_kctrl = WE & HIT & (reg_sel == REG_KCTRL);
  assign wr_sctrl = WE & HIT & (reg_sel == REG_SCTRL);

  // Only DIN[0], DIN[1] and (optionally) DIN[4] carry meaning. The other bits
  // are folded here so that the bus width does not have to match the register layout.
  assign unused_din = ^DIN;

  keysw_debounce #(
    .W          (4),
    .DEB_CYCLES (DEB_CYCLES),
    .CNTBITS    (CNTBITS),
    .RST_VAL    (4'hF)
  ) u_key_deb (
    .clk   (CLK),
    .rst_n (RESET_N),
    .raw   (KEY),
    .deb   (kdeb),
    .chg   (kchg)
  );

  keysw_debounce #(
    .W          (10),
    .DEB_CYCLES (DEB_CYCLES),
    .CNTBITS    (CNTBITS),
    .RST_VAL    (10'h000)
  ) u_sw_deb (
    .clk   (CLK),
    .rst_n (RESET_N),
    .raw   (SW),
    .deb   (sdeb),
    .chg   (schg)
  );

  keysw_flags u_key_flags (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .chg     (kchg),
    .rd_data (rd_kdata),
    .wr_ctrl (wr_kctrl),
    .din_rdy (DIN[0]),
    .din_ovr (DIN[1]),
    .rdy     (krdy),
    .ovr     (kovr)
  );

  keysw_flags u_sw_flags (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .chg     (schg),
    .rd_data (rd_sdata),
    .wr_ctrl (wr_sctrl),
    .din_rdy (DIN[0]),
    .din_ovr (DIN[1]),
    .rdy     (srdy),
    .ovr     (sovr)
  );

`ifdef KEYSW_IRQ_EN
  // Interrupt enables, written through the control registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      kie <= 1'b0;
      sie <= 1'b0;
    end else begin
      if (wr_kctrl) kie <= DIN[4];
      if (wr_sctrl) sie <= DIN[4];
    end
  end

  // Registered interrupt request, so it lags the flags by one cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) IRQ <= 1'b0;
    else          IRQ <= (krdy & kie) | (srdy & sie);
  end
`else
  assign kie = 1'b0;
  assign sie = 1'b0;
  assign IRQ = 1'b0;
`endif

  // Load data: pure combinational decode of ADDR. RE is not involved.
  // NOTE: DOUT gets a default before the case, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    DOUT = '0;
    if (HIT) begin
      case (reg_sel)
        REG_KDATA: DOUT = DBITS'(kdeb);
        REG_SDATA: DOUT = DBITS'(sdeb);
        REG_KCTRL: DOUT = DBITS'({kie, 2'b00, kovr, krdy});
        REG_SCTRL: DOUT = DBITS'({sie, 2'b00, sovr, srdy});
        default:   DOUT = '0;
      endcase
    end
  end

endmodule

// File: doc/keysw_mmio_dev.md
Name: keysw_mmio_dev

Overview:
- Memory-mapped input peripheral; the responder side of the processor's data-memory bus for the 0xFFF0–0xFFF6 I/O window.
- Synchronises and debounces KEY[3:0] and SW[9:0], and exposes data and status/control registers.
- Sets sticky "ready"/"overrun" flags so software can poll for input changes instead of re-reading raw levels.
- Sits beside the memory array; its DOUT is muxed into the load-data path when HIT is high.

Parameters:
- DBITS, 16, bus data/address width.
- DEB_CYCLES, 500000, consecutive stable cycles required before a debounced value updates (minimum 2).
- CNTBITS, 20, debounce counter width; must satisfy 2^CNTBITS > DEB_CYCLES.
- BASE, 16'hFFF0, address of register 0; registers sit at BASE+0, +2, +4, +6.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- KEY  in  4  raw pushbuttons, asynchronous, active-low.
- SW  in  10  raw switches, asynchronous.
- ADDR  in  DBITS  bus byte address.
- RE  in  1  read strobe, one cycle per load.
- WE  in  1  write strobe, one cycle per store.
- DIN  in  DBITS  store data.
- DOUT  out  DBITS  load data, combinational from ADDR.
- HIT  out  1  high when ADDR is in BASE..BASE+6 and ADDR[0]==0.
- IRQ  out  1  interrupt request (see Optional Feature).

Behaviour:
- Register map:
  - BASE+0 KDATA (RO): {12'b0, kdeb[3:0]}.
  - BASE+2 SDATA (RO): {6'b0, sdeb[9:0]}.
  - BASE+4 KCTRL: bit0 RDY, bit1 OVR, bit4 IE; other bits read 0.
  - BASE+6 SCTRL: same layout as KCTRL.
- Reads:
  - DOUT is a pure combinational decode of ADDR.
  - DOUT=0 when HIT=0 or ADDR[0]=1.
  - RE has no effect on DOUT.
- Synchroniser: two flops per input bit. Reset values: KEY path 4'hF, SW path 10'h000.
- Debounce, one independent engine per group (K, S), each with a candidate reg cand, a counter cnt, and a debounced reg deb:
  - if sync!=cand: cand<=sync, cnt<=0.
  - else if cnt==DEB_CYCLES-1: cnt holds. If deb!=cand: deb<=cand and assert a one-cycle chg pulse.
  - else: cnt<=cnt+1.
- Input-to-deb latency: 2 sync cycles + DEB_CYCLES stable cycles + 1 cycle.
- Reset values: cand and deb = sync reset values (kdeb=4'hF, sdeb=0); cnt=0.
- Flag update per group, at each posedge:
  - chg & RDY=1 -> OVR<=1.
  - chg -> RDY<=1.
  - RE & ADDR==data register -> RDY<=0; OVR unchanged.
  - WE & ADDR==ctrl register -> RDY<=RDY&DIN[0], OVR<=OVR&DIN[1] (write 0 to clear), IE<=DIN[4].
- Priority: a chg in the same cycle as a clear (read or write) wins. RDY ends 1; OVR is not set by that chg.
- Writes to KDATA/SDATA or to unmapped addresses are ignored.
- Writes take effect at the next edge; a read in the following cycle sees the new value.
- Reset mid-debounce: all state returns to reset values immediately. Flags RDY=0, OVR=0, IE=0. DOUT reflects reset state combinationally.
- The RE and WE strobes are sampled only when HIT=1.

Optional Feature:
- KEYSW_IRQ_EN defined:
  - IRQ is registered: IRQ <= (KCTRL.RDY&KCTRL.IE)|(SCTRL.RDY&SCTRL.IE). Reset 0.
  - IRQ deasserts one cycle after the condition clears.
- KEYSW_IRQ_EN undefined:
  - IRQ tied 0.
  - The IE bits are not implemented: they read 0 and writes to them are ignored.

Test Plan:
- Reset, DEB_CYCLES=4: hold RESET_N=0, KEY=4'h0. Read BASE+0 -> 16'h000F. Read BASE+4 -> 16'h0000. IRQ=0.
- Debounce: SW=10'h155 held. SDATA=0 for the first 6 cycles, then SDATA=16'h0155 on the 7th cycle; SCTRL reads 16'h0001.
- Bounce: toggle KEY[0] every 2 cycles for 20 cycles, then hold 0. KDATA stays 16'h000F until 7 cycles after the last toggle, then reads 16'h000E.
- Flags: with KCTRL.RDY=1, cause a second key change -> KCTRL=16'h0003. Read KDATA with RE -> KCTRL=16'h0002. Write 16'h0000 to BASE+4 -> KCTRL=16'h0000.
- Collision: a chg pulse in the same cycle as RE on SDATA -> SCTRL.RDY=1, OVR=0.
- IRQ (with KEYSW_IRQ_EN): write 16'h0010 to BASE+6, then change SW -> IRQ=1 one cycle after RDY sets. Read SDATA -> IRQ=0 two cycles after RE.
